// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory over req/ack, holds the word until the core commits.
// Fetch latency 1 cycle plus memory wait; the fetched word is held until adv; no ack within TIMEOUT cycles -> one idle cycle, then retry.
module ifetch_unit #(
    parameter logic [31:0] RST_VECTOR = 32'h0000_0000,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcp,
    input  logic        adv,
    output logic        imReq,
    output logic [31:0] imAddr,
    input  logic        imAck,
    input  logic [31:0] imData,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        instVld,
    output logic        fault,
    output logic [31:0] icnt
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, RETRY} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] tcnt;

    // Request is a pure state decode so an async reset drops it in the same cycle.
    assign imReq  = (state == FETCH);
    assign imAddr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RST_VECTOR;
            inst    <= 32'h0;
            instVld <= 1'b0;
            fault   <= 1'b0;
            icnt    <= 32'h0;
            tcnt    <= 8'h0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imAck) begin
                        inst    <= imData;
                        instVld <= 1'b1;
                        tcnt    <= 8'h0;
                        state   <= HOLD;
                    end else if (tcnt == TLAST) begin
                        fault <= 1'b1;
                        tcnt  <= 8'h0;
                        state <= RETRY;
                    end else begin
                        tcnt <= tcnt + 8'h1;
                    end
                end
                RETRY: state <= FETCH;
                HOLD: begin
                    // adv wins over any stray ack arriving in the same cycle
                    if (adv) begin
                        pc      <= {pcp[31:2], 2'b00};
                        icnt    <= icnt + 32'h1;
                        instVld <= 1'b0;
                        state   <= FETCH;
                        if (pcp[1:0] != 2'b00)
                            fault <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: boot, sequential fetch, wait states, branch, timeout retry, misalignment, reset, wrap.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcp;
    logic        adv;
    logic        imReq;
    logic [31:0] imAddr;
    logic        imAck;
    logic [31:0] imData;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        instVld;
    logic        fault;
    logic [31:0] icnt;

    int tests = 0;
    int fails = 0;

    ifetch_unit #(.RST_VECTOR(32'h0040_0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .pcp(pcp), .adv(adv),
        .imReq(imReq), .imAddr(imAddr), .imAck(imAck), .imData(imData),
        .pc(pc), .inst(inst), .instVld(instVld), .fault(fault), .icnt(icnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; adv = 1'b0; pcp = 32'h0; imAck = 1'b0; imData = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(imReq),   32'h0);
        chk("rst_pc",    pc,           32'h0040_0000);
        chk("rst_inst",  inst,         32'h0);
        chk("rst_vld",   32'(instVld), 32'h0);
        chk("rst_fault", 32'(fault),   32'h0);
        chk("rst_icnt",  icnt,         32'h0);

        // boot: first fetch at the reset vector, zero-wait ack
        rst = 1'b0;
        @(negedge clk);
        chk("boot_req",  32'(imReq), 32'h1);
        chk("boot_addr", imAddr,     32'h0040_0000);
        imAck = 1'b1; imData = 32'h2008_0005;
        @(negedge clk);
        imAck = 1'b0;
        chk("boot_vld",  32'(instVld), 32'h1);
        chk("boot_inst", inst,         32'h2008_0005);
        chk("boot_pc",   pc,           32'h0040_0000);
        chk("boot_req0", 32'(imReq),   32'h0);
        adv = 1'b1; pcp = 32'h0;
        @(negedge clk);
        adv = 1'b0;

        // sequential run, one instruction per two cycles
        for (int i = 0; i < 3; i++) begin
            chk("seq_req",  32'(imReq), 32'h1);
            chk("seq_addr", imAddr,     32'(i * 4));
            imAck = 1'b1; imData = 32'h1000_0000 + 32'(i);
            @(negedge clk);
            imAck = 1'b0;
            chk("seq_vld",  32'(instVld), 32'h1);
            chk("seq_req0", 32'(imReq),   32'h0);
            chk("seq_inst", inst,         32'h1000_0000 + 32'(i));
            adv = 1'b1; pcp = 32'(i * 4 + 4);
            @(negedge clk);
            adv = 1'b0;
        end
        chk("seq_icnt", icnt, 32'd4);

        // three wait states at 0xC, then branch to 0x100
        for (int k = 0; k < 3; k++) begin
            chk("wait_vld",  32'(instVld), 32'h0);
            chk("wait_inst", inst,         32'h1000_0002);
            chk("wait_addr", imAddr,       32'h0000_000C);
            @(negedge clk);
        end
        chk("wait_vld3", 32'(instVld), 32'h0);
        imAck = 1'b1; imData = 32'h8C0A_0010;
        @(negedge clk);
        imAck = 1'b0;
        chk("wait_vld4", 32'(instVld), 32'h1);
        chk("wait_inst", inst,         32'h8C0A_0010);
        chk("wait_pc",   pc,           32'h0000_000C);
        adv = 1'b1; pcp = 32'h0000_0100;
        @(negedge clk);
        adv = 1'b0;
        chk("br_addr", imAddr,     32'h0000_0100);
        chk("br_req",  32'(imReq), 32'h1);
        chk("br_icnt", icnt,       32'd5);

        // timeout: never ack -> 4 cycles requesting, 1 idle, retry same address
        for (int k = 0; k < 4; k++) begin
            chk("to_req",   32'(imReq), 32'h1);
            chk("to_addr",  imAddr,     32'h0000_0100);
            chk("to_fault", 32'(fault), 32'h0);
            @(negedge clk);
        end
        chk("to_gap_req",   32'(imReq), 32'h0);
        chk("to_gap_fault", 32'(fault), 32'h1);
        chk("to_gap_addr",  imAddr,     32'h0000_0100);
        @(negedge clk);
        chk("to_retry_req",  32'(imReq), 32'h1);
        chk("to_retry_addr", imAddr,     32'h0000_0100);
        imAck = 1'b1; imData = 32'h2409_0001;
        @(negedge clk);
        imAck = 1'b0;
        chk("to_vld",    32'(instVld), 32'h1);
        chk("to_inst",   inst,         32'h2409_0001);
        chk("to_sticky", 32'(fault),   32'h1);
        adv = 1'b1; pcp = 32'h0000_0300;
        @(negedge clk);
        adv = 1'b0;
        chk("to_pc",   pc,   32'h0000_0300);
        chk("to_icnt", icnt, 32'd6);

        // adv outside HOLD is ignored
        adv = 1'b1; pcp = 32'h0000_0500;
        @(negedge clk);
        adv = 1'b0;
        chk("ign_pc",   pc,         32'h0000_0300);
        chk("ign_icnt", icnt,       32'd6);
        chk("ign_req",  32'(imReq), 32'h1);

        // async reset while requesting
        rst = 1'b1;
        #1;
        chk("ar_req",   32'(imReq),   32'h0);
        chk("ar_pc",    pc,           32'h0040_0000);
        chk("ar_inst",  inst,         32'h0);
        chk("ar_vld",   32'(instVld), 32'h0);
        chk("ar_fault", 32'(fault),   32'h0);
        chk("ar_icnt",  icnt,         32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_boot_addr", imAddr, 32'h0040_0000);
        imAck = 1'b1; imData = 32'h0000_0020;
        @(negedge clk);
        imAck = 1'b0;

        // misaligned target
        adv = 1'b1; pcp = 32'h0000_0206;
        @(negedge clk);
        adv = 1'b0;
        chk("mis_pc",    pc,         32'h0000_0204);
        chk("mis_addr",  imAddr,     32'h0000_0204);
        chk("mis_fault", 32'(fault), 32'h1);
        chk("mis_icnt",  icnt,       32'd1);
        imAck = 1'b1; imData = 32'h0000_0040;
        @(negedge clk);
        imAck = 1'b0;

        // counter wrap, with a stray ack in the committing HOLD cycle
        force dut.icnt = 32'hFFFF_FFFF;
        #1;
        release dut.icnt;
        adv = 1'b1; pcp = 32'h0000_0208; imAck = 1'b1; imData = 32'hDEAD_BEEF;
        @(negedge clk);
        adv = 1'b0; imAck = 1'b0;
        chk("wrap_icnt", icnt,         32'h0);
        chk("wrap_pc",   pc,           32'h0000_0208);
        chk("wrap_inst", inst,         32'h0000_0040);
        chk("wrap_vld",  32'(instVld), 32'h0);
        chk("wrap_req",  32'(imReq),   32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
